// File: rtl/rx_ctrl.sv
// rtl/rx_ctrl.sv - UART receive sequencer: start qualification, mid-bit timing, stop/parity check
//
// Ports:
//   clk         system clock
//   rx_rst      synchronous active-high reset
//   tick        one-clk pulse at OVERSAMPLE x baud
//   rx          raw asynchronous serial line, idle high
//   par_odd     parity sense (1 = odd), used only with RX_PARITY_EN
//   sipo_en     one-clk shift strobe to the SIPO at mid-bit
//   sipo_rst    one-clk SIPO clear at frame start
//   data_valid  one-clk pulse: frame good, SIPO holds the data
//   frame_err   one-clk pulse: stop bit sampled low
//   parity_err  one-clk pulse: parity mismatch (tied 0 unless RX_PARITY_EN)
//   busy        high in every state except IDLE
//
// Optional feature macro: RX_PARITY_EN adds a PARITY bit period after DATA.

module rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic clk,
    input  logic rx_rst,
    input  logic tick,
    input  logic rx,
    input  logic par_odd,
    output logic sipo_en,
    output logic sipo_rst,
    output logic data_valid,
    output logic frame_err,
    output logic parity_err,
    output logic busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    NBITS   = 4'(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          sync1_q, sync2_q;
    logic          rx_s;
    logic          sipo_en_q, sipo_en_d;
    logic          sipo_rst_q, sipo_rst_d;
    logic          data_valid_q, data_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;

    assign rx_s = sync2_q;

`ifdef RX_PARITY_EN
    logic par_acc_q, par_acc_d;     // running XOR of sampled data bits
    logic par_bad_q, par_bad_d;     // parity verdict, held until the stop sample
    logic parity_err_q, parity_err_d;
`else
    logic unused_par_odd;
    assign unused_par_odd = par_odd;
`endif

    // Synchroniser presets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rx_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_rst) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            sipo_en_q    <= 1'b0;
            sipo_rst_q   <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            sipo_en_q    <= sipo_en_d;
            sipo_rst_q   <= sipo_rst_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rx_rst) begin
            par_acc_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_acc_q    <= par_acc_d;
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        sipo_en_d    = 1'b0;
        sipo_rst_d   = 1'b0;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef RX_PARITY_EN
        par_acc_d    = par_acc_q;
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                        sipo_rst_d = 1'b1;
                    end
                end
                // Half a bit period here places every later sample at mid-bit.
                S_START: begin
                    if (tick_cnt_q == HALF_M1) begin
                        if (rx_s) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d    = S_DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
`ifdef RX_PARITY_EN
                            par_acc_d  = 1'b0;
                            par_bad_d  = 1'b0;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == FULL_M1) begin
                        sipo_en_d  = 1'b1;
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + 4'd1;
`ifdef RX_PARITY_EN
                        par_acc_d  = par_acc_q ^ rx_s;
`endif
                        if (bit_cnt_q + 4'd1 == NBITS) begin
`ifdef RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`ifdef RX_PARITY_EN
                S_PARITY: begin
                    if (tick_cnt_q == FULL_M1) begin
                        par_bad_d  = rx_s != (par_acc_q ^ par_odd);
                        tick_cnt_d = '0;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tick_cnt_q == FULL_M1) begin
                        data_valid_d = rx_s;
                        frame_err_d  = !rx_s;
`ifdef RX_PARITY_EN
                        parity_err_d = par_bad_q;
`endif
                        tick_cnt_d   = '0;
                        state_d      = S_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    tick_cnt_d = '0;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    assign sipo_en    = sipo_en_q;
    assign sipo_rst   = sipo_rst_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
`ifdef RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
